vad: RTL and testbench

//   Energy + zero-crossing-rate voice activity detector for a 16-bit PCM stream (16 kHz, one strobe per sample).

---
 rtl/vad_pkg.sv | 14 +
 rtl/vad_window_features.sv | 69 ++++++
 rtl/vad.sv | 121 ++++++++++++
 tb/tb_vad.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vad_pkg.sv
// Voice activity detector: shared constants and sample-count derivation.
package vad_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned ZC_W  = 16;

  function automatic int unsigned ms_to_samples(
    input int unsigned rate,
    input int unsigned ms
  );
    return rate * ms / 1000;
  endfunction

endpackage

// File: rtl/vad_window_features.sv
// Per-window |x| energy and zero-crossing accumulation with window_done strobe.
module vad_window_features
  import vad_pkg::*;
#(
  parameter int unsigned WIN_SAMPLES = 160
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      audio_i,
  input  logic             valid_i,
  output logic [ACC_W-1:0] energy_o,
  output logic [ZC_W-1:0]  zc_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(WIN_SAMPLES);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ZC_W-1:0]  zc_q, zc_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;
  logic [16:0]      mag;
  logic             last;

  assign last = (cnt_q == CW'(WIN_SAMPLES - 1));

  always_comb begin
    mag    = audio_i[15] ? (17'd0 - {audio_i[15], audio_i})
                         : {1'b0, audio_i};
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    zc_d   = zc_q;
    sign_d = sign_q;
    done_d = valid_i & last;
    // the clk after a window closes clears, but a strobe there opens the next
    if (done_q) begin
      acc_d = '0;
      zc_d  = '0;
    end
    if (valid_i) begin
      cnt_d  = last ? '0 : cnt_q + CW'(1);
      acc_d  = acc_d + ACC_W'(mag);
      zc_d   = zc_d + ZC_W'(audio_i[15] ^ sign_q);
      sign_d = audio_i[15];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      zc_q   <= '0;
      sign_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      zc_q   <= zc_d;
      sign_q <= sign_d;
      done_q <= done_d;
    end
  end

  assign energy_o = acc_q;
  assign zc_o     = zc_q;
  assign done_o   = done_q;

endmodule

// File: rtl/vad.sv
// Voice activity detector top: smoothing, adaptive noise floor,
// window decision, hangover hold and pre-trigger pulse.
module vad
  import vad_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE          = 16000,
  parameter int unsigned CLK_FREQ             = 100_000_000,
  parameter logic [31:0] THRESHOLD_OFF        = 32'd1_000_000,
  parameter int unsigned THRESHOLD_ADAPT_RATE = 4,
  parameter int unsigned ZCR_MIN_SPEECH       = 15,
  parameter int unsigned ZCR_MAX_SPEECH       = 45,
  parameter int unsigned HANGOVER_MS          = 300,
  parameter int unsigned WINDOW_MS            = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_in,
  input  logic        sample_valid,
  output logic        speech_detected,
  output logic        vad_raw,
  output logic        pre_trigger_pulse,
  output logic        recording_active,
  output logic [31:0] smoothed_energy,
  output logic [31:0] noise_floor,
  output logic [15:0] zero_cross_rate
);

  localparam int unsigned WIN  = ms_to_samples(SAMPLE_RATE, WINDOW_MS);
  localparam int unsigned HANG = ms_to_samples(SAMPLE_RATE, HANGOVER_MS);
  localparam int unsigned HW   = $clog2(HANG + 1);

  if (CLK_FREQ < SAMPLE_RATE) begin : g_clk_chk
    $error("vad: CLK_FREQ must be at least SAMPLE_RATE");
  end

  logic [ACC_W-1:0] win_e;
  logic [ZC_W-1:0]  win_z;
  logic             win_done;

  logic [31:0]        se_q, se_d, nf_q, nf_d, se_n;
  logic [15:0]        zcr_q, zcr_d;
  logic               vad_q, vad_d;
  logic               sd_q, sd_d;
  logic               pulse_q, pulse_d;
  logic [HW-1:0]      hang_q, hang_d;
  logic [32:0]        thr;
  logic signed [32:0] diff, step;
  logic               e_act, z_act;

  vad_window_features #(
    .WIN_SAMPLES (WIN)
  ) u_feat (
    .clk_i    (clk),
    .rst_i    (rst),
    .audio_i  (audio_in),
    .valid_i  (sample_valid),
    .energy_o (win_e),
    .zc_o     (win_z),
    .done_o   (win_done)
  );

  always_comb begin
    se_n  = se_q - (se_q >> 1) + (win_e >> 1);
    thr   = {1'b0, nf_q} + {1'b0, THRESHOLD_OFF};
    diff  = $signed({1'b0, win_e}) - $signed({1'b0, nf_q});
    step  = diff >>> THRESHOLD_ADAPT_RATE;
    e_act = {1'b0, se_n} > thr;
    z_act = (win_z >= ZC_W'(ZCR_MIN_SPEECH)) &&
            (win_z <= ZC_W'(ZCR_MAX_SPEECH));
    se_d   = se_q;
    nf_d   = nf_q;
    zcr_d  = zcr_q;
    vad_d  = vad_q;
    hang_d = hang_q;
    if (win_done) begin
      se_d  = se_n;
      zcr_d = win_z;
      vad_d = e_act & z_act;
      // floor tracks only quiet windows; loud ones leave it frozen
      if ({1'b0, win_e} <= thr) begin
        nf_d = 32'($signed({1'b0, nf_q}) + step);
      end
    end
    if (win_done && vad_d) begin
      hang_d = HW'(HANG);
    end else if (sample_valid && hang_q != '0) begin
      hang_d = hang_q - HW'(1);
    end
    sd_d    = vad_d | (hang_d != '0);
    pulse_d = sd_d & ~sd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      se_q    <= '0;
      nf_q    <= '0;
      zcr_q   <= '0;
      vad_q   <= 1'b0;
      sd_q    <= 1'b0;
      pulse_q <= 1'b0;
      hang_q  <= '0;
    end else begin
      se_q    <= se_d;
      nf_q    <= nf_d;
      zcr_q   <= zcr_d;
      vad_q   <= vad_d;
      sd_q    <= sd_d;
      pulse_q <= pulse_d;
      hang_q  <= hang_d;
    end
  end

  assign speech_detected   = sd_q;
  assign recording_active  = sd_q;
  assign vad_raw           = vad_q;
  assign pre_trigger_pulse = pulse_q;
  assign smoothed_energy   = se_q;
  assign noise_floor       = nf_q;
  assign zero_cross_rate   = zcr_q;

endmodule

// File: tb/tb_vad.sv
// Scoreboard bench for vad: directed phases push expected snapshots,
// a negedge monitor pops and compares them at the scheduled sample count.
module tb_vad;

  logic        clk;
  logic        rst;
  logic [15:0] audio_in;
  logic        sample_valid;
  logic        speech_detected;
  logic        vad_raw;
  logic        pre_trigger_pulse;
  logic        recording_active;
  logic [31:0] smoothed_energy;
  logic [31:0] noise_floor;
  logic [15:0] zero_cross_rate;

  vad dut (
    .clk               (clk),
    .rst               (rst),
    .audio_in          (audio_in),
    .sample_valid      (sample_valid),
    .speech_detected   (speech_detected),
    .vad_raw           (vad_raw),
    .pre_trigger_pulse (pre_trigger_pulse),
    .recording_active  (recording_active),
    .smoothed_energy   (smoothed_energy),
    .noise_floor       (noise_floor),
    .zero_cross_rate   (zero_cross_rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     at;
    string  name;
    int     vad;
    int     sd;
    int     zcr;
    longint se;
    longint nf;
    int     pl;
    int     pz;
  } exp_t;

  exp_t q[$];
  int   nsamp  = 0;
  int   npulse = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic expect_at(input int at, input string name,
                           input int vad, input int sd, input int zcr,
                           input longint se, input longint nf,
                           input int pl, input int pz);
    exp_t e;
    e.at = at; e.name = name; e.vad = vad; e.sd = sd; e.zcr = zcr;
    e.se = se; e.nf = nf; e.pl = pl; e.pz = pz;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pre_trigger_pulse) npulse++;
    while (q.size() > 0 && nsamp >= q[0].at) begin
      e = q.pop_front();
      chk({e.name, ".vad_raw"}, longint'(vad_raw), e.vad);
      chk({e.name, ".speech"}, longint'(speech_detected), e.sd);
      chk({e.name, ".rec"}, longint'(recording_active), e.sd);
      chk({e.name, ".zcr"}, longint'(zero_cross_rate), e.zcr);
      chk({e.name, ".energy"}, longint'(smoothed_energy), e.se);
      chk({e.name, ".floor"}, longint'(noise_floor), e.nf);
      chk({e.name, ".pulses"}, longint'(npulse), e.pl);
      chk({e.name, ".pulse"}, longint'(pre_trigger_pulse), e.pz);
    end
  end

  task automatic send(input logic [15:0] v);
    audio_in     = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    nsamp++;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) send(16'd0);
  endtask

  task automatic talk(input int n);
    for (int i = 0; i < n; i++)
      send(((i / 5) % 2 == 0) ? -16'sd8000 : 16'sd8000);
  endtask

  task automatic buzz(input int n);
    for (int i = 0; i < n; i++)
      send((i % 2 == 0) ? -16'sd8000 : 16'sd8000);
  endtask

  task automatic hum(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    audio_in     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(0, "reset", 0, 0, 0, 0, 0, 0, 0);

    expect_at(800, "silence", 0, 0, 0, 0, 0, 0, -1);
    zeros(800);

    expect_at(1120, "talk_w2", 0, 0, 32, 960000, 0, 0, 0);
    expect_at(1280, "talk_w3", 1, 1, 32, 1120000, 0, 1, 1);
    expect_at(4000, "talk_end", 1, 1, 32, 1279999, 0, 1, 0);
    talk(3200);

    expect_at(4160, "quiet_w1", 0, 1, 0, 640000, 0, 1, 0);
    expect_at(5600, "hang_1600", 0, 1, 0, 1250, 0, 1, 0);
    expect_at(8799, "hang_last", 0, 1, -1, -1, 0, 1, 0);
    expect_at(8800, "hang_exp", 0, 0, 0, -1, 0, 1, 0);
    zeros(4800);

    expect_at(12480, "buzz_w3", 0, 0, 160, 1120001, 0, 1, 0);
    expect_at(15200, "buzz_end", 0, 0, 160, -1, 0, 1, 0);
    zeros(3200);
    buzz(3200);

    expect_at(17120, "again_w2", 0, 0, 32, -1, 0, 1, 0);
    expect_at(17280, "again_w3", 1, 1, 32, -1, 0, 2, 1);
    expect_at(17600, "again_end", 1, 1, 32, -1, 0, 2, 0);
    zeros(1600);
    talk(800);

    expect_at(17760, "floor_up1", 0, 1, 0, -1, 10000, 2, 0);
    expect_at(17920, "floor_up2", 0, 1, 0, -1, 19375, 2, 0);
    expect_at(18080, "floor_down", 0, 1, 0, -1, 18164, 2, 0);
    hum(320, 16'd1000);
    zeros(160);

    talk(370);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_at(nsamp, "mid_reset", 0, 0, 0, 0, 0, 2, 0);
    expect_at(nsamp + 159, "restart_159", 0, 0, 0, 0, 0, 2, 0);
    expect_at(nsamp + 160, "restart_160", 0, 0, 160, 640000, 0, 2, 0);
    buzz(160);

    repeat (4) @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got never-checked expected checked at %0d",
               e.name, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
